// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: round-robin sharing of one DMA controller among N_REQ requesters,
// grant held per transfer, with a watchdog that aborts transfers stalled without ctl_ack.
module dma_rr_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req_rqst,
  input  logic [N_REQ-1:0]    req_rd_wr,
  input  logic [16*N_REQ-1:0] req_addr,
  input  logic [16*N_REQ-1:0] req_nwords,
  input  logic [16*N_REQ-1:0] req_dev_out,
  input  logic [N_REQ-1:0]    req_dev_ack,
  output logic [N_REQ-1:0]    req_ack,
  output logic [15:0]         req_dev_in,
  output logic [N_REQ-1:0]    req_end,
  output logic [N_REQ-1:0]    req_error,
  output logic                ctl_rqst,
  output logic                ctl_rd_wr,
  output logic [15:0]         ctl_addr,
  output logic [15:0]         ctl_nwords,
  output logic [15:0]         ctl_dev_out,
  output logic                ctl_dev_ack,
  input  logic                ctl_ack,
  input  logic [15:0]         ctl_dev_in,
  input  logic                ctl_end_flag,
  input  logic                ctl_error_flag,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
);
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t           r_state, w_next;
  logic [N_REQ-1:0] r_grant, w_win_oh;
  logic [LW-1:0]    r_last, w_win;
  logic [TO_W-1:0]  r_wd;
  logic             r_to, w_to, w_g_rqst;
  // Scan from the farthest candidate down so the first requester after r_last wins.
  always_comb begin
    w_win = r_last;
    for (int k = N_REQ; k >= 1; k--)
      if (req_rqst[(int'(r_last) + k) % N_REQ]) w_win = LW'((int'(r_last) + k) % N_REQ);
  end
  assign w_win_oh = N_REQ'(1) << w_win;
  always_comb begin
    ctl_rd_wr   = 1'b0;
    ctl_dev_ack = 1'b0;
    ctl_addr    = '0;
    ctl_nwords  = '0;
    ctl_dev_out = '0;
    for (int i = 0; i < N_REQ; i++)
      if (r_grant[i]) begin
        ctl_rd_wr   = ctl_rd_wr | req_rd_wr[i];
        ctl_dev_ack = ctl_dev_ack | req_dev_ack[i];
        ctl_addr    = ctl_addr | req_addr[16*i +: 16];
        ctl_nwords  = ctl_nwords | req_nwords[16*i +: 16];
        ctl_dev_out = ctl_dev_out | req_dev_out[16*i +: 16];
      end
  end
  assign w_g_rqst = |(req_rqst & r_grant);
  assign w_to     = (r_state == GRANT) && (r_wd == TO_W'(TIMEOUT - 1)) && !ctl_ack;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |req_rqst ? GRANT : IDLE;
      GRANT:   w_next = (ctl_end_flag || ctl_error_flag || !w_g_rqst || w_to) ? RELEASE : GRANT;
      RELEASE: w_next = (!ctl_end_flag && !ctl_error_flag && !w_g_rqst) ? IDLE : RELEASE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LW'(N_REQ - 1);
      r_wd    <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_to    <= w_to;
      r_wd    <= (r_state == GRANT && !ctl_ack) ? ((&r_wd) ? r_wd : r_wd + 1'b1) : '0;
      if (r_state == IDLE && w_next == GRANT) begin
        r_grant <= w_win_oh;
        r_last  <= w_win;
      end else if (r_state == RELEASE && w_next == IDLE) begin
        r_grant <= '0;
      end
    end
  end
  assign ctl_rqst   = w_g_rqst && (r_state == GRANT);
  assign req_ack    = {N_REQ{ctl_ack}} & r_grant;
  assign req_end    = {N_REQ{ctl_end_flag}} & r_grant;
  assign req_error  = {N_REQ{ctl_error_flag | r_to}} & r_grant;
  assign req_dev_in = |r_grant ? ctl_dev_in : '0;
  assign grant      = r_grant;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_dma_rr_arbiter.sv
// tb_dma_rr_arbiter: directed cycle-by-cycle vectors for the 2-requester arbiter (TIMEOUT=8),
// plus short hand-written checks of the data path muxing.
module tb_dma_rr_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  req_rqst = '0, req_rd_wr, req_dev_ack = '0;
  logic [31:0] req_addr, req_nwords, req_dev_out;
  logic [1:0]  req_ack, req_end, req_error, grant;
  logic [15:0] req_dev_in, ctl_addr, ctl_nwords, ctl_dev_out, ctl_dev_in = '0;
  logic        ctl_rqst, ctl_rd_wr, ctl_dev_ack, busy;
  logic        ctl_ack = 1'b0, ctl_end_flag = 1'b0, ctl_error_flag = 1'b0;
  int          n_chk = 0, n_pass = 0;

  dma_rr_arbiter #(.N_REQ(2), .TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_rqst(req_rqst), .req_rd_wr(req_rd_wr),
    .req_addr(req_addr), .req_nwords(req_nwords), .req_dev_out(req_dev_out),
    .req_dev_ack(req_dev_ack), .req_ack(req_ack), .req_dev_in(req_dev_in),
    .req_end(req_end), .req_error(req_error), .ctl_rqst(ctl_rqst), .ctl_rd_wr(ctl_rd_wr),
    .ctl_addr(ctl_addr), .ctl_nwords(ctl_nwords), .ctl_dev_out(ctl_dev_out),
    .ctl_dev_ack(ctl_dev_ack), .ctl_ack(ctl_ack), .ctl_dev_in(ctl_dev_in),
    .ctl_end_flag(ctl_end_flag), .ctl_error_flag(ctl_error_flag), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  rq;
    logic        ack, en, er;
    logic [25:0] exp;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(input bit rst, input logic [1:0] rq, input logic ack, en, er,
                              input logic [1:0] g, input logic cr, bz,
                              input logic [1:0] ra, re, rerr, input logic [15:0] addr);
    mk.rst = rst; mk.rq = rq; mk.ack = ack; mk.en = en; mk.er = er;
    mk.exp = {g, cr, bz, ra, re, rerr, addr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // req0: read 4 words @0x0200; req1: write 3 words @0x1234
    req_addr = {16'h1234, 16'h0200};
    req_nwords = {16'd3, 16'd4};
    req_dev_out = {16'hA5A5, 16'h5A5A};
    req_rd_wr = 2'b01;
    // rst, rq, ack, end, err | grant, ctl_rqst, busy, req_ack, req_end, req_error, ctl_addr
    v.push_back(mk(1, 2'b00, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    // single requester
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b01,1,1, 2'b00,2'b00,2'b00, 16'h0200));
    for (int i = 0; i < 4; i++)
      v.push_back(mk(0, 2'b01, 1,0,0, 2'b01,1,1, 2'b01,2'b00,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b01, 0,1,0, 2'b01,1,1, 2'b00,2'b01,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b00, 0,0,0, 2'b01,0,1, 2'b00,2'b00,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b00, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    // simultaneous requests from reset; req0 first, then req1 beats req0's re-request
    v.push_back(mk(1, 2'b00, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    v.push_back(mk(0, 2'b11, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    v.push_back(mk(0, 2'b11, 0,0,0, 2'b01,1,1, 2'b00,2'b00,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b11, 0,1,0, 2'b01,1,1, 2'b00,2'b01,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b10, 0,0,0, 2'b01,0,1, 2'b00,2'b00,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b11, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    v.push_back(mk(0, 2'b11, 0,0,0, 2'b10,1,1, 2'b00,2'b00,2'b00, 16'h1234));
    // abort by req1
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b10,0,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b10,0,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    // timeout: 8 GRANT cycles without ack, error pulse for one cycle, req1 unaffected
    for (int i = 0; i < 8; i++)
      v.push_back(mk(0, 2'b11, 0,0,0, 2'b01,1,1, 2'b00,2'b00,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b11, 0,0,0, 2'b01,0,1, 2'b00,2'b00,2'b01, 16'h0200));
    v.push_back(mk(0, 2'b10, 0,0,0, 2'b01,0,1, 2'b00,2'b00,2'b00, 16'h0200));
    v.push_back(mk(0, 2'b10, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    // error flag during req1 write; RELEASE held while flag high
    v.push_back(mk(0, 2'b10, 0,0,0, 2'b10,1,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b10, 1,0,0, 2'b10,1,1, 2'b10,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b10, 0,0,1, 2'b10,1,1, 2'b00,2'b00,2'b10, 16'h1234));
    v.push_back(mk(0, 2'b00, 0,0,1, 2'b10,0,1, 2'b00,2'b00,2'b10, 16'h1234));
    v.push_back(mk(0, 2'b01, 0,0,1, 2'b10,0,1, 2'b00,2'b00,2'b10, 16'h1234));
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b10,0,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    // reset mid-GRANT, then arbitration restarts with last=1
    v.push_back(mk(0, 2'b01, 0,0,0, 2'b01,1,1, 2'b00,2'b00,2'b00, 16'h0200));
    v.push_back(mk(1, 2'b01, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    v.push_back(mk(0, 2'b10, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));
    v.push_back(mk(0, 2'b10, 0,0,0, 2'b10,1,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b00, 0,0,0, 2'b10,0,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b00, 0,0,0, 2'b10,0,1, 2'b00,2'b00,2'b00, 16'h1234));
    v.push_back(mk(0, 2'b00, 0,0,0, 2'b00,0,0, 2'b00,2'b00,2'b00, 16'h0000));

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      reset_n = !v[i].rst;
      req_rqst = v[i].rq;
      ctl_ack = v[i].ack;
      ctl_end_flag = v[i].en;
      ctl_error_flag = v[i].er;
      #1;
      chk($sformatf("vec%0d", i),
          {6'b0, grant, ctl_rqst, busy, req_ack, req_end, req_error, ctl_addr},
          {6'b0, v[i].exp});
    end

    // data path of granted req1 (last=1 -> req1 wins when alone)
    @(negedge clk); req_rqst = 2'b10;
    @(negedge clk); ctl_dev_in = 16'hBEEF; req_dev_ack = 2'b10; #1;
    chk("g1_grant", 32'(grant), 32'h2);
    chk("g1_nwords", 32'(ctl_nwords), 32'd3);
    chk("g1_rd_wr", 32'(ctl_rd_wr), 32'd0);
    chk("g1_dev_out", 32'(ctl_dev_out), 32'hA5A5);
    chk("g1_dev_ack", 32'(ctl_dev_ack), 32'd1);
    chk("g1_dev_in", 32'(req_dev_in), 32'hBEEF);
    req_dev_ack = 2'b01; #1;
    chk("g1_dev_ack_other", 32'(ctl_dev_ack), 32'd0);
    @(negedge clk); req_rqst = 2'b00; req_dev_ack = 2'b00;
    @(negedge clk);
    // data path of granted req0 (last=1 -> req0 wins)
    @(negedge clk); req_rqst = 2'b01;
    @(negedge clk); req_dev_ack = 2'b01; #1;
    chk("g0_grant", 32'(grant), 32'h1);
    chk("g0_nwords", 32'(ctl_nwords), 32'd4);
    chk("g0_rd_wr", 32'(ctl_rd_wr), 32'd1);
    chk("g0_dev_out", 32'(ctl_dev_out), 32'h5A5A);
    chk("g0_dev_ack", 32'(ctl_dev_ack), 32'd1);
    @(negedge clk); req_rqst = 2'b00; req_dev_ack = 2'b00;
    @(negedge clk);
    @(negedge clk); #1;
    chk("final_idle", {30'b0, busy, ctl_rqst}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
